// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg: register selects and CTRL field layout shared by the divider block.
package clk_div_multi_pkg;
    // c_addr[0] picks which channel register a write targets
    typedef enum logic {
        REG_LIMIT = 1'b0,
        REG_CTRL  = 1'b1
    } reg_sel_e;
    // CTRL register fields
    localparam int   CTRL_EN_BIT   = 0;
    localparam int   CTRL_MODE_BIT = 1;
    localparam logic MODE_CLK      = 1'b0;
    localparam logic MODE_STB      = 1'b1;
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel holding counter, limit, enable and mode.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   apply       : 1-cycle strobe, load apply_data into the register named by apply_reg
//   apply_reg   : REG_LIMIT or REG_CTRL
//   apply_data  : new limit, or CTRL bits {mode, enable} in [1:0]
//   wrap        : combinational period-end flag (enabled and cnt == limit)
//   en          : current enable, used by the top to steer apply timing
//   clkout      : 50% divided clock (mode 0) or 1-cycle strobe (mode 1)
//   tick        : registered wrap event, 1 cycle per period
module clk_div_channel
    import clk_div_multi_pkg::*;
#(
    parameter int                   WIDTH_CNT   = 24,
    parameter logic [WIDTH_CNT-1:0] RESET_LIMIT = '0,
    parameter logic                 RESET_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 apply,
    input  reg_sel_e             apply_reg,
    input  logic [WIDTH_CNT-1:0] apply_data,
    output logic                 wrap,
    output logic                 en,
    output logic                 clkout,
    output logic                 tick
);
    logic [WIDTH_CNT-1:0] cnt;
    logic [WIDTH_CNT-1:0] limit;
    logic                 mode;
    logic                 apply_ctrl;
    logic                 restart;
    logic                 clkout_nxt;

    assign wrap       = en && (cnt == limit);
    assign apply_ctrl = apply && (apply_reg == REG_CTRL);
    // Disabling or switching mode restarts clkout from 0; since CTRL only lands
    // at a period boundary, this can only stretch a low phase, never chop a pulse.
    assign restart    = apply_ctrl &&
                        (!apply_data[CTRL_EN_BIT] || (apply_data[CTRL_MODE_BIT] != mode));

    always_comb begin
        clkout_nxt = (restart || !en) ? 1'b0 :
                     (mode == MODE_STB) ? wrap : (clkout ^ wrap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            limit  <= RESET_LIMIT;
            en     <= RESET_EN;
            mode   <= MODE_CLK;
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else begin
            cnt    <= (en && !wrap) ? cnt + 1'b1 : '0;
            tick   <= wrap;
            clkout <= clkout_nxt;
            if (apply_ctrl) begin
                en   <= apply_data[CTRL_EN_BIT];
                mode <= apply_data[CTRL_MODE_BIT];
            end
            if (apply && (apply_reg == REG_LIMIT))
                limit <= apply_data;
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock/tick generator with glitch-free reconfiguration.
//   clk, rst_n : system clock, asynchronous active-low reset
//   c_addr     : [0] register select (0 LIMIT, 1 CTRL), [MSB:1] channel index
//   c_data     : LIMIT value in [WIDTH_CNT-1:0]; CTRL enable in [0], mode in [1]
//   c_valid    : config write request, transfers when c_valid & c_ready
//   c_ready    : no write pending in the shadow slot
//   c_err      : 1-cycle pulse after an accepted write to a nonexistent channel
//   clkout     : per-channel divided clock or strobe
//   tick       : per-channel 1-cycle pulse per period
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int                          NUM_CH            = 4,
    parameter int                          WIDTH_CNT         = 24,
    parameter int                          WIDTH_CONFIG_ADDR = 8,
    parameter int                          WIDTH_CONFIG_DATA = 32,
    parameter logic [NUM_CH*WIDTH_CNT-1:0] RESET_LIMITS      = '0,
    parameter logic [NUM_CH-1:0]           RESET_EN          = '1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
    input  logic                         c_valid,
    output logic                         c_ready,
    output logic                         c_err,
    output logic [NUM_CH-1:0]            clkout,
    output logic [NUM_CH-1:0]            tick
);
    localparam int CHW = WIDTH_CONFIG_ADDR - 1;

    logic                 pend;
    logic [CHW-1:0]       sh_ch;
    reg_sel_e             sh_reg;
    logic [WIDTH_CNT-1:0] sh_data;
    logic [CHW-1:0]       req_ch;
    logic                 mapped;
    logic                 accept;
    logic [NUM_CH-1:0]    wrap;
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH-1:0]    apply;
    logic                 unused_data;

    assign req_ch      = c_addr[WIDTH_CONFIG_ADDR-1:1];
    assign mapped      = int'(req_ch) < NUM_CH;
    assign c_ready     = ~pend;
    assign accept      = c_valid && c_ready;
    assign unused_data = ^c_data[WIDTH_CONFIG_DATA-1:WIDTH_CNT];

    // Unmapped writes never occupy the shadow slot; they only raise c_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            sh_ch   <= '0;
            sh_reg  <= REG_LIMIT;
            sh_data <= '0;
            c_err   <= 1'b0;
        end else begin
            c_err <= accept && !mapped;
            if (accept && mapped) begin
                pend    <= 1'b1;
                sh_ch   <= req_ch;
                sh_reg  <= reg_sel_e'(c_addr[0]);
                sh_data <= c_data[WIDTH_CNT-1:0];
            end else if (|apply) begin
                pend <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Running channels take the write at their period boundary; idle ones at once.
        assign apply[i] = pend && (sh_ch == CHW'(i)) && (wrap[i] || !en[i]);

        clk_div_channel #(
            .WIDTH_CNT  (WIDTH_CNT),
            .RESET_LIMIT(RESET_LIMITS[i*WIDTH_CNT +: WIDTH_CNT]),
            .RESET_EN   (RESET_EN[i])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .apply     (apply[i]),
            .apply_reg (sh_reg),
            .apply_data(sh_data),
            .wrap      (wrap[i]),
            .en        (en[i]),
            .clkout    (clkout[i]),
            .tick      (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized and directed checks of clk_div_multi against a period-timestamp model.
module tb_clk_div_multi;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_data = '0;
    logic          c_valid = 1'b0;
    logic          c_ready;
    logic          c_err;
    logic [N-1:0]  clkout;
    logic [N-1:0]  tick;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH           (N),
        .WIDTH_CNT        (W),
        .WIDTH_CONFIG_ADDR(AW),
        .WIDTH_CONFIG_DATA(DW),
        .RESET_LIMITS     ({8'd5, 8'd3, 8'd2, 8'd1}),
        .RESET_EN         (4'b1111)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .c_addr (c_addr),
        .c_data (c_data),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .c_err  (c_err),
        .clkout (clkout),
        .tick   (tick)
    );

    // Model: each running channel is described by the absolute cycle of its next wrap.
    int          rst_lim[N] = '{1, 2, 3, 5};
    bit          m_en[N];
    bit          m_mode[N];
    int          m_lim[N];
    int          m_next[N];
    bit          m_clk[N];
    bit          m_tick[N];
    bit          m_pend;
    int          m_ch;
    bit          m_reg;
    logic [31:0] m_data;
    bit          m_err;
    int          t;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_en[c]   = 1'b1;
            m_mode[c] = 1'b0;
            m_lim[c]  = rst_lim[c];
            m_next[c] = rst_lim[c];
            m_clk[c]  = 1'b0;
            m_tick[c] = 1'b0;
        end
        m_pend = 1'b0;
        m_err  = 1'b0;
        t      = 0;
    endfunction

    task automatic compare();
        logic [N-1:0] ec, et;
        for (int c = 0; c < N; c++) begin
            ec[c] = m_clk[c];
            et[c] = m_tick[c];
        end
        check("clkout", 32'(clkout), 32'(ec));
        check("tick", 32'(tick), 32'(et));
        check("c_ready", 32'(c_ready), 32'(!m_pend));
        check("c_err", 32'(c_err), 32'(m_err));
    endtask

    // Advance model and DUT by one clock, then compare.
    task automatic step(output bit acc);
        bit w[N];
        bit ap[N];
        int ach;
        acc = c_valid && !m_pend;
        ach = int'(c_addr[AW-1:1]);
        for (int c = 0; c < N; c++) begin
            w[c]  = m_en[c] && (t == m_next[c]);
            ap[c] = m_pend && (m_ch == c) && (w[c] || !m_en[c]);
        end
        for (int c = 0; c < N; c++) begin
            m_tick[c] = w[c];
            if (!m_en[c]) m_clk[c] = 1'b0;
            else if (m_mode[c]) m_clk[c] = w[c];
            else if (w[c]) m_clk[c] = !m_clk[c];
            if (w[c]) m_next[c] = t + 1 + m_lim[c];
            if (ap[c]) begin
                if (m_reg) begin
                    if (!m_data[0] || (m_data[1] != m_mode[c])) m_clk[c] = 1'b0;
                    if (!m_en[c] && m_data[0]) m_next[c] = t + 1 + m_lim[c];
                    m_en[c]   = m_data[0];
                    m_mode[c] = m_data[1];
                end else begin
                    m_lim[c] = int'(m_data & 32'hFF);
                    if (w[c]) m_next[c] = t + 1 + m_lim[c];
                end
                m_pend = 1'b0;
            end
        end
        m_err = acc && (ach >= N);
        if (acc && ach < N) begin
            m_pend = 1'b1;
            m_ch   = ach;
            m_reg  = c_addr[0];
            m_data = c_data;
        end
        @(posedge clk);
        t++;
        #1;
        compare();
    endtask

    task automatic run(input int n);
        bit acc;
        repeat (n) step(acc);
    endtask

    task automatic wr(input int ch, input bit rs, input logic [31:0] d);
        bit acc;
        int k;
        c_addr  = {7'(ch), rs};
        c_data  = d;
        c_valid = 1'b1;
        acc     = 1'b0;
        for (k = 0; k < 64 && !acc; k++) step(acc);
        check("write_accept", 32'(acc), 32'd1);
        c_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int k;
        t = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clkout", 32'(clkout), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ready", 32'(c_ready), 32'd1);
        check("rst_err", 32'(c_err), 32'd0);
        rst_n = 1'b1;
        model_reset();

        run(12);
        wr(0, 1'b0, 32'd3);
        run(20);
        wr(1, 1'b0, 32'd4);
        wr(1, 1'b1, 32'd3);
        run(15);
        for (k = 0; k < 20 && !clkout[2]; k++) step(acc);
        check("ch2_high_seen", 32'(clkout[2]), 32'd1);
        wr(2, 1'b1, 32'd0);
        run(10);
        wr(2, 1'b1, 32'd1);
        run(12);
        wr(5, 1'b0, 32'd7);
        run(4);
        wr(127, 1'b1, 32'd0);
        run(4);
        wr(0, 1'b0, 32'hABCDEF02);
        run(12);

        repeat (1500) begin
            c_valid = ($urandom % 4) == 0;
            c_addr  = {7'($urandom_range(0, 5)), 1'($urandom % 2)};
            c_data  = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 6));
            if (c_addr[0] && ($urandom % 4) != 0) c_data = c_data | 32'd1;
            step(acc);
        end
        c_valid = 1'b0;
        run(40);

        wr(3, 1'b1, 32'd1);
        wr(3, 1'b0, 32'd6);
        check("pending_before_reset", 32'(c_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_clkout", 32'(clkout), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_ready", 32'(c_ready), 32'd1);
        check("async_err", 32'(c_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
